// File: rtl/readreg.sv
// readreg: register-read stage between rename and issue.
// Requests both source physical registers per lane from the register file and
// resolves each operand from register-file data or execute/writeback bypass.
// The datapath is purely combinational; clk is present only for interface uniformity.
// Optional feature macro: READREG_WB_BYPASS_EN (writeback feedback joins the bypass
// as the lowest-priority source when defined).

package readreg_pkg;
  localparam int unsigned READREG_WIDTH    = 2;
  localparam int unsigned EXECUTE_UNIT_NUM = 7;
  localparam int unsigned PHY_REG_ID_WIDTH = 6;
  localparam int unsigned REG_DATA_WIDTH   = 32;
  localparam int unsigned PC_WIDTH         = 32;
  localparam int unsigned OP_WIDTH         = 8;

  typedef enum logic [1:0] {
    _reg     = 2'd0,
    _imm     = 2'd1,
    _disable = 2'd2
  } arg_src_t;

  typedef struct packed {
    logic                        enable;
    logic                        valid;
    logic [PC_WIDTH-1:0]         pc;
    logic [OP_WIDTH-1:0]         op;
    logic [REG_DATA_WIDTH-1:0]   imm;
    arg_src_t                    arg1_src;
    arg_src_t                    arg2_src;
    logic                        rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0] rs1_phy;
    logic                        rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0] rs2_phy;
    logic                        rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
  } rename_readreg_op_info_t;

  typedef struct packed {
    rename_readreg_op_info_t [READREG_WIDTH-1:0] op_info;
  } rename_readreg_pack_t;

  typedef struct packed {
    logic                        enable;
    logic                        valid;
    logic [PC_WIDTH-1:0]         pc;
    logic [OP_WIDTH-1:0]         op;
    logic [REG_DATA_WIDTH-1:0]   imm;
    arg_src_t                    arg1_src;
    arg_src_t                    arg2_src;
    logic                        rs1_need_map;
    logic [PHY_REG_ID_WIDTH-1:0] rs1_phy;
    logic                        rs2_need_map;
    logic [PHY_REG_ID_WIDTH-1:0] rs2_phy;
    logic                        rd_enable;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
    logic                        src1_loaded;
    logic [REG_DATA_WIDTH-1:0]   src1_value;
    logic                        src2_loaded;
    logic [REG_DATA_WIDTH-1:0]   src2_value;
  } readreg_issue_op_info_t;

  typedef struct packed {
    readreg_issue_op_info_t [READREG_WIDTH-1:0] op_info;
  } readreg_issue_pack_t;

  typedef struct packed {
    logic stall;
  } issue_feedback_pack_t;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [REG_DATA_WIDTH-1:0]   value;
  } feedback_channel_t;

  typedef struct packed {
    feedback_channel_t [EXECUTE_UNIT_NUM-1:0] channel;
  } execute_feedback_pack_t;

  typedef execute_feedback_pack_t wb_feedback_pack_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

  typedef struct packed {
    logic                      loaded;
    logic [REG_DATA_WIDTH-1:0] value;
  } operand_t;
endpackage

module readreg
  import readreg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  rename_readreg_pack_t   rename_readreg_port_data_out,
  output logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] readreg_phyf_id,
  input  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   phyf_readreg_data,
  input  logic [READREG_WIDTH-1:0][1:0]                       phyf_readreg_data_valid,
  output readreg_issue_pack_t    readreg_issue_port_data_in,
  output logic                   readreg_issue_port_we,
  output logic                   readreg_issue_port_flush,
  input  issue_feedback_pack_t   issue_feedback_pack,
  input  execute_feedback_pack_t execute_feedback_pack,
  input  wb_feedback_pack_t      wb_feedback_pack,
  input  commit_feedback_pack_t  commit_feedback_pack
);

  operand_t [READREG_WIDTH-1:0][1:0] w_exe_hit;
  operand_t [READREG_WIDTH-1:0][1:0] w_wb_hit;
  operand_t [READREG_WIDTH-1:0][1:0] w_opnd;
  logic                              w_unused;

  // Bypass lookup: scanning high to low lets the lowest-index matching channel win.
  function automatic operand_t fb_lookup(input execute_feedback_pack_t fb,
                                         input logic [PHY_REG_ID_WIDTH-1:0] phy);
    operand_t r;
    r = '0;
    for (int k = int'(EXECUTE_UNIT_NUM) - 1; k >= 0; k--) begin
      if (fb.channel[k].enable && (fb.channel[k].phy_id == phy)) begin
        r.loaded = 1'b1;
        r.value  = fb.channel[k].value;
      end
    end
    return r;
  endfunction

  // Operand resolution: immediate / constant zero first, then RF, execute, writeback.
  function automatic operand_t resolve(input logic                      active,
                                       input arg_src_t                  src,
                                       input logic                      need_map,
                                       input logic [REG_DATA_WIDTH-1:0] imm,
                                       input logic                      rf_valid,
                                       input logic [REG_DATA_WIDTH-1:0] rf_data,
                                       input operand_t                  exe_hit,
                                       input operand_t                  wb_hit);
    operand_t r;
    r = '0;
    if (active) begin
      if (src == _imm) begin
        r.loaded = 1'b1;
        r.value  = imm;
      end else if ((src == _disable) || !need_map) begin
        r.loaded = 1'b1;
      end else if (rf_valid) begin
        r.loaded = 1'b1;
        r.value  = rf_data;
      end else if (exe_hit.loaded) begin
        r = exe_hit;
      end else begin
        r = wb_hit;
      end
    end
    return r;
  endfunction

  // Register-file read ids and per-operand bypass hits.
  always_comb begin
    readreg_phyf_id = '0;
    w_exe_hit       = '0;
    w_wb_hit        = '0;
    for (int i = 0; i < int'(READREG_WIDTH); i++) begin
      readreg_phyf_id[i][0] = rename_readreg_port_data_out.op_info[i].rs1_phy;
      readreg_phyf_id[i][1] = rename_readreg_port_data_out.op_info[i].rs2_phy;
      for (int n = 0; n < 2; n++) begin
        w_exe_hit[i][n] = fb_lookup(execute_feedback_pack, readreg_phyf_id[i][n]);
`ifdef READREG_WB_BYPASS_EN
        w_wb_hit[i][n]  = fb_lookup(wb_feedback_pack, readreg_phyf_id[i][n]);
`endif
      end
    end
  end

  // Final operand selection per lane.
  always_comb begin
    w_opnd = '0;
    for (int i = 0; i < int'(READREG_WIDTH); i++) begin
      w_opnd[i][0] = resolve(rename_readreg_port_data_out.op_info[i].enable &
                             rename_readreg_port_data_out.op_info[i].valid,
                             rename_readreg_port_data_out.op_info[i].arg1_src,
                             rename_readreg_port_data_out.op_info[i].rs1_need_map,
                             rename_readreg_port_data_out.op_info[i].imm,
                             phyf_readreg_data_valid[i][0], phyf_readreg_data[i][0],
                             w_exe_hit[i][0], w_wb_hit[i][0]);
      w_opnd[i][1] = resolve(rename_readreg_port_data_out.op_info[i].enable &
                             rename_readreg_port_data_out.op_info[i].valid,
                             rename_readreg_port_data_out.op_info[i].arg2_src,
                             rename_readreg_port_data_out.op_info[i].rs2_need_map,
                             rename_readreg_port_data_out.op_info[i].imm,
                             phyf_readreg_data_valid[i][1], phyf_readreg_data[i][1],
                             w_exe_hit[i][1], w_wb_hit[i][1]);
    end
  end

  // Issue packet: pass every rename field through and attach resolved operands.
  always_comb begin
    readreg_issue_port_data_in = '0;
    for (int i = 0; i < int'(READREG_WIDTH); i++) begin
      readreg_issue_port_data_in.op_info[i].enable       = rename_readreg_port_data_out.op_info[i].enable;
      readreg_issue_port_data_in.op_info[i].valid        = rename_readreg_port_data_out.op_info[i].valid;
      readreg_issue_port_data_in.op_info[i].pc           = rename_readreg_port_data_out.op_info[i].pc;
      readreg_issue_port_data_in.op_info[i].op           = rename_readreg_port_data_out.op_info[i].op;
      readreg_issue_port_data_in.op_info[i].imm          = rename_readreg_port_data_out.op_info[i].imm;
      readreg_issue_port_data_in.op_info[i].arg1_src     = rename_readreg_port_data_out.op_info[i].arg1_src;
      readreg_issue_port_data_in.op_info[i].arg2_src     = rename_readreg_port_data_out.op_info[i].arg2_src;
      readreg_issue_port_data_in.op_info[i].rs1_need_map = rename_readreg_port_data_out.op_info[i].rs1_need_map;
      readreg_issue_port_data_in.op_info[i].rs1_phy      = rename_readreg_port_data_out.op_info[i].rs1_phy;
      readreg_issue_port_data_in.op_info[i].rs2_need_map = rename_readreg_port_data_out.op_info[i].rs2_need_map;
      readreg_issue_port_data_in.op_info[i].rs2_phy      = rename_readreg_port_data_out.op_info[i].rs2_phy;
      readreg_issue_port_data_in.op_info[i].rd_enable    = rename_readreg_port_data_out.op_info[i].rd_enable;
      readreg_issue_port_data_in.op_info[i].rd_phy       = rename_readreg_port_data_out.op_info[i].rd_phy;
      readreg_issue_port_data_in.op_info[i].src1_loaded  = w_opnd[i][0].loaded;
      readreg_issue_port_data_in.op_info[i].src1_value   = w_opnd[i][0].value;
      readreg_issue_port_data_in.op_info[i].src2_loaded  = w_opnd[i][1].loaded;
      readreg_issue_port_data_in.op_info[i].src2_value   = w_opnd[i][1].value;
    end
  end

  // Issue-port control; reset holds both low without touching the datapath.
  assign readreg_issue_port_we    = ~issue_feedback_pack.stall & ~rst;
  assign readreg_issue_port_flush = commit_feedback_pack.enable & commit_feedback_pack.flush & ~rst;

`ifdef READREG_WB_BYPASS_EN
  assign w_unused = clk;
`else
  assign w_unused = ^{clk, wb_feedback_pack};
`endif

endmodule

// File: tb/tb_readreg.sv
// tb_readreg: directed self-checking bench for the readreg register-read stage.
module tb_readreg;
  import readreg_pkg::*;

  logic                   clk;
  logic                   rst;
  rename_readreg_pack_t   rr;
  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] ids;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   rf_data;
  logic [READREG_WIDTH-1:0][1:0]                       rf_valid;
  readreg_issue_pack_t    iss;
  logic                   we;
  logic                   flush;
  issue_feedback_pack_t   ifb;
  execute_feedback_pack_t exe;
  wb_feedback_pack_t      wb;
  commit_feedback_pack_t  cfb;

  int n_checks = 0;
  int n_pass   = 0;

  readreg dut (
    .clk                          (clk),
    .rst                          (rst),
    .rename_readreg_port_data_out (rr),
    .readreg_phyf_id              (ids),
    .phyf_readreg_data            (rf_data),
    .phyf_readreg_data_valid      (rf_valid),
    .readreg_issue_port_data_in   (iss),
    .readreg_issue_port_we        (we),
    .readreg_issue_port_flush     (flush),
    .issue_feedback_pack          (ifb),
    .execute_feedback_pack        (exe),
    .wb_feedback_pack             (wb),
    .commit_feedback_pack         (cfb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Check both operands of every lane against loaded flags and values.
  task automatic check_ops(input string tag,
                           input logic [READREG_WIDTH-1:0][1:0] exp_ld,
                           input logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0] exp_val);
    for (int i = 0; i < int'(READREG_WIDTH); i++) begin
      check($sformatf("%s l%0d s1_loaded", tag, i), 64'(iss.op_info[i].src1_loaded), 64'(exp_ld[i][0]));
      check($sformatf("%s l%0d s1_value",  tag, i), 64'(iss.op_info[i].src1_value),  64'(exp_val[i][0]));
      check($sformatf("%s l%0d s2_loaded", tag, i), 64'(iss.op_info[i].src2_loaded), 64'(exp_ld[i][1]));
      check($sformatf("%s l%0d s2_value",  tag, i), 64'(iss.op_info[i].src2_value),  64'(exp_val[i][1]));
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [READREG_WIDTH-1:0][1:0]                     e_ld;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0] e_val;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    rr = '0; rf_data = '0; rf_valid = '0; exe = '0; wb = '0;
    ifb.stall = 1'b0;
    cfb.enable = 1'b1; cfb.flush = 1'b1;
    for (int i = 0; i < int'(READREG_WIDTH); i++) begin
      rr.op_info[i].enable       = 1'b1;
      rr.op_info[i].valid        = 1'b1;
      rr.op_info[i].pc           = 32'h1000 + 32'(4 * i);
      rr.op_info[i].op           = 8'(8'h30 + i);
      rr.op_info[i].imm          = 32'h100 + 32'(i);
      rr.op_info[i].arg1_src     = _reg;
      rr.op_info[i].arg2_src     = _reg;
      rr.op_info[i].rs1_need_map = 1'b1;
      rr.op_info[i].rs1_phy      = PHY_REG_ID_WIDTH'(i);
      rr.op_info[i].rs2_need_map = 1'b1;
      rr.op_info[i].rs2_phy      = PHY_REG_ID_WIDTH'(i + 2);
      rr.op_info[i].rd_enable    = 1'b1;
      rr.op_info[i].rd_phy       = PHY_REG_ID_WIDTH'(10 + i);
    end
    #1;
    // Reset holds control low even with flush requested; datapath still live.
    check("rst we", 64'(we), 64'd0);
    check("rst flush", 64'(flush), 64'd0);
    for (int i = 0; i < int'(READREG_WIDTH); i++)
      for (int j = 0; j < 2; j++)
        check($sformatf("rst id[%0d][%0d]", i, j), 64'(ids[i][j]), 64'(i + 2 * j));

    step(); rst = 1'b0; cfb.enable = 1'b0; #1;
    check("release we", 64'(we), 64'd1);
    check("release flush", 64'(flush), 64'd0);

    // Register-file priority over matching execute channels.
    step();
    rf_valid = '1;
    for (int i = 0; i < int'(READREG_WIDTH); i++)
      for (int j = 0; j < 2; j++)
        rf_data[i][j] = 32'hcdea1574 + 32'(i + 2 * j);
    for (int k = 0; k < int'(EXECUTE_UNIT_NUM); k++) begin
      exe.channel[k].enable = 1'b1;
      exe.channel[k].phy_id = PHY_REG_ID_WIDTH'(k);
      exe.channel[k].value  = 32'hacde1285 + 32'(k);
    end
    #1;
    for (int i = 0; i < int'(READREG_WIDTH); i++)
      for (int j = 0; j < 2; j++) begin
        e_ld[i][j] = 1'b1; e_val[i][j] = 32'hcdea1574 + 32'(i + 2 * j);
      end
    check_ops("rf", e_ld, e_val);
    check("pass pc1", 64'(iss.op_info[1].pc), 64'h1004);
    check("pass rd0", 64'(iss.op_info[0].rd_phy), 64'd10);
    check("pass op1", 64'(iss.op_info[1].op), 64'h31);

    // Execute bypass when the register file is not ready.
    step(); rf_valid = '0; #1;
    for (int i = 0; i < int'(READREG_WIDTH); i++)
      for (int j = 0; j < 2; j++) e_val[i][j] = 32'hacde1285 + 32'(i + 2 * j);
    check_ops("exe", e_ld, e_val);

    // Lowest-index channel wins; disabled channel is skipped.
    step();
    exe.channel[1].enable = 1'b0;
    exe.channel[5].phy_id = 6'd1; exe.channel[5].value = 32'h5555_0001;
    exe.channel[6].phy_id = 6'd3; exe.channel[6].value = 32'hdead_beef;
    #1;
    check("exe skip disabled", 64'(iss.op_info[1].src1_value), 64'h5555_0001);
    check("exe lowest wins", 64'(iss.op_info[1].src2_value), 64'hacde1288);

    // Miss: execute off, writeback ids do not match.
    step();
    exe = '0;
    for (int k = 0; k < int'(EXECUTE_UNIT_NUM); k++) begin
      wb.channel[k].enable = 1'b1;
      wb.channel[k].phy_id = PHY_REG_ID_WIDTH'(int'(EXECUTE_UNIT_NUM) + k);
      wb.channel[k].value  = 32'h4a5cddef + 32'(k);
    end
    #1;
    e_ld = '0; e_val = '0;
    check_ops("miss", e_ld, e_val);

    // Writeback bypass hit.
    step();
    for (int k = 0; k < int'(EXECUTE_UNIT_NUM); k++) wb.channel[k].phy_id = PHY_REG_ID_WIDTH'(k);
    #1;
`ifdef READREG_WB_BYPASS_EN
    for (int i = 0; i < int'(READREG_WIDTH); i++)
      for (int j = 0; j < 2; j++) begin
        e_ld[i][j] = 1'b1; e_val[i][j] = 32'h4a5cddef + 32'(i + 2 * j);
      end
`endif
    check_ops("wb", e_ld, e_val);

    // Immediate, disabled and x0 operands; RF beats writeback on lane 1 rs2.
    step();
    rr.op_info[0].arg1_src     = _imm;
    rr.op_info[0].arg2_src     = _disable;
    rr.op_info[1].rs1_need_map = 1'b0;
    rf_valid[1][1] = 1'b1; rf_data[1][1] = 32'h0000_0055;
    #1;
    e_ld = '1;
    e_val[0][0] = 32'h100; e_val[0][1] = '0; e_val[1][0] = '0; e_val[1][1] = 32'h55;
    check_ops("kinds", e_ld, e_val);

    // Inactive lanes report nothing loaded but still pass fields through.
    step();
    rr.op_info[0].enable = 1'b0;
    rr.op_info[1].valid  = 1'b0;
    #1;
    e_ld = '0; e_val = '0;
    check_ops("inactive", e_ld, e_val);
    check("inactive pc0", 64'(iss.op_info[0].pc), 64'h1000);
    check("inactive valid1", 64'(iss.op_info[1].valid), 64'd0);

    // Control combinations.
    step(); ifb.stall = 1'b0; cfb.enable = 1'b0; cfb.flush = 1'b1; #1;
    check("ctl idle we", 64'(we), 64'd1);
    check("ctl idle flush", 64'(flush), 64'd0);
    step(); cfb.enable = 1'b1; cfb.flush = 1'b0; #1;
    check("ctl commit noflush", 64'(flush), 64'd0);
    step(); cfb.flush = 1'b1; #1;
    check("ctl flush", 64'(flush), 64'd1);
    check("ctl flush we", 64'(we), 64'd1);
    step(); ifb.stall = 1'b1; #1;
    check("ctl stall flush", 64'(flush), 64'd1);
    check("ctl stall we", 64'(we), 64'd0);

    // Asynchronous reset mid-run, applied away from the clock edge.
    step(); ifb.stall = 1'b0; #2; rst = 1'b1; #1;
    check("rst2 we", 64'(we), 64'd0);
    check("rst2 flush", 64'(flush), 64'd0);
    step(); rst = 1'b0; #1;
    check("rst2 release we", 64'(we), 64'd1);
    check("rst2 release flush", 64'(flush), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
